// File: rtl/reg_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_unit_pkg
// Description : Shared CPU register-file widths and dump FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_unit_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_SEND = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = c_IDLE,
        S_READ = c_READ,
        S_SEND = c_SEND,
        S_DONE = c_DONE
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_unit_if
// Description : Valid/ready word stream from the register dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_unit_if
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_unit
// Description : Walks a wrapping register range through one read port and
//               streams each value out while holding the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    input  wire logic              start,
    input  wire logic              abort,
    input  wire logic [ADDR_W-1:0] first_reg,
    input  wire logic [ADDR_W-1:0] last_reg,
    output logic      [ADDR_W-1:0] rd_addr,
    input  wire logic [DATA_W-1:0] rd_data,
    output logic                   hold_cpu,
    output logic                   busy,
    output logic                   done,
    reg_dump_unit_if.master        strm
);

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_last;

    logic w_accept_start;
    logic w_capture;
    logic w_advance;
    logic w_at_end;

    assign w_at_end = (r_cur == r_end);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks everything, including a handshake in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_capture      = 1'b0;
        w_advance      = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_accept_start = 1'b1;
                        w_state_nxt    = S_READ;
                    end
                end
                S_READ: begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end
                S_SEND: begin
                    if (strm.out_ready) begin
                        if (w_at_end) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_advance   = 1'b1;
                            w_state_nxt = S_READ;
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cur  <= '0;
            r_end  <= '0;
            r_data <= '0;
            r_addr <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_cur <= first_reg;
                r_end <= last_reg;
            end else if (w_advance) begin
                r_cur <= r_cur + ADDR_W'(1);
            end
            if (w_capture) begin
                r_data <= rd_data;
                r_addr <= r_cur;
                r_last <= w_at_end;
            end
        end
    end

    assign rd_addr        = r_cur;
    assign busy           = (r_state != S_IDLE);
    assign hold_cpu       = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign strm.out_valid = (r_state == S_SEND);
    assign strm.out_data  = r_data;
    assign strm.out_addr  = r_addr;
    assign strm.out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_unit
// Description : Scoreboard bench for reg_dump_unit over a modelled register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;
    import reg_dump_unit_pkg::*;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic        abort;
    logic [3:0]  first_reg;
    logic [3:0]  last_reg;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        hold_cpu;
    logic        busy;
    logic        done;
    logic [15:0] regs [16];

    exp_t        sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rx_cnt = 0;
    int          ready_mode = 0;
    logic        have_prev = 1'b0;
    logic [15:0] prev_d;
    logic [3:0]  prev_a;
    logic        prev_l;

    reg_dump_unit_if s_if ();

    reg_dump_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .hold_cpu  (hold_cpu),
        .busy      (busy),
        .done      (done),
        .strm      (s_if)
    );

    always #5 CLK = ~CLK;

    assign rd_data = regs[rd_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queues the expected word sequence, then pulses start for one edge.
    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        logic [3:0] span;
        logic [3:0] a;
        exp_t       e;
        span = l - f;
        for (int k = 0; k <= int'(span); k++) begin
            a   = f + 4'(k);
            e.a = a;
            e.d = regs[a];
            e.l = (k == int'(span));
            sb_q.push_back(e);
        end
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0:       s_if.out_ready = 1'b1;
            1:       s_if.out_ready = ($urandom_range(0, 9) < 3);
            default: s_if.out_ready = 1'b0;
        endcase
    end

    // Stream monitor: pops on handshake, checks stability under backpressure.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET || abort) begin
            sb_q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("stall_valid", 32'(s_if.out_valid), 32'd1);
                chk("stall_data",  32'(s_if.out_data),  32'(prev_d));
                chk("stall_addr",  32'(s_if.out_addr),  32'(prev_a));
                chk("stall_last",  32'(s_if.out_last),  32'(prev_l));
                have_prev = 1'b0;
            end
            if (s_if.out_valid) begin
                chk("hold_cpu_in_send", 32'(hold_cpu), 32'd1);
                if (s_if.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("word_addr", 32'(s_if.out_addr), 32'(e.a));
                        chk("word_data", 32'(s_if.out_data), 32'(e.d));
                        chk("word_last", 32'(s_if.out_last), 32'(e.l));
                        rx_cnt++;
                    end
                end else begin
                    prev_d    = s_if.out_data;
                    prev_a    = s_if.out_addr;
                    prev_l    = s_if.out_last;
                    have_prev = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        logic seen;
        RESET      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_reg  = 4'd0;
        last_reg   = 4'd0;
        ready_mode = 0;
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        regs[3] = 16'h1111;
        regs[4] = 16'h2222;
        regs[5] = 16'h3333;

        repeat (3) tick();
        @(negedge CLK);
        chk("rst_valid",  32'(s_if.out_valid), 32'd0);
        chk("rst_data",   32'(s_if.out_data),  32'd0);
        chk("rst_addr",   32'(s_if.out_addr),  32'd0);
        chk("rst_last",   32'(s_if.out_last),  32'd0);
        chk("rst_rdaddr", 32'(rd_addr),        32'd0);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_hold",   32'(hold_cpu),       32'd0);
        chk("rst_done",   32'(done),           32'd0);
        tick();
        RESET = 1'b1;
        tick();

        // Three-word dump with exact cycle timing
        base = rx_cnt;
        start_dump(4'd3, 4'd5);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            case (c)
                1: begin
                    chk("lat_busy",  32'(busy),           32'd1);
                    chk("lat_hold",  32'(hold_cpu),       32'd1);
                    chk("lat_valid", 32'(s_if.out_valid), 32'd0);
                end
                2: chk("lat_first_valid", 32'(s_if.out_valid), 32'd1);
                7: chk("done_n7", 32'(done), 32'd1);
                8: begin
                    chk("busy_n8", 32'(busy), 32'd0);
                    chk("done_n8", 32'(done), 32'd0);
                end
                default: chk("done_early", 32'(done), 32'd0);
            endcase
        end
        chk("cnt_3word", 32'(rx_cnt - base), 32'd3);
        chk("sb_3word",  32'(sb_q.size()),   32'd0);
        tick();

        // Wrapping range
        base = rx_cnt;
        start_dump(4'd14, 4'd1);
        wait_done(100, "done_wrap");
        chk("cnt_wrap", 32'(rx_cnt - base), 32'd4);
        chk("sb_wrap",  32'(sb_q.size()),   32'd0);
        tick();

        // Full 16-word dump under random backpressure
        ready_mode = 1;
        base = rx_cnt;
        start_dump(4'd7, 4'd6);
        wait_done(600, "done_full");
        chk("cnt_full", 32'(rx_cnt - base), 32'd16);
        chk("sb_full",  32'(sb_q.size()),   32'd0);
        ready_mode = 0;
        tick();

        // Single-word dump
        base = rx_cnt;
        start_dump(4'd9, 4'd9);
        wait_done(20, "done_single");
        chk("cnt_single", 32'(rx_cnt - base), 32'd1);
        tick();

        // Abort on the handshake of word 2 of 4; a busy start must be ignored
        base = rx_cnt;
        start_dump(4'd4, 4'd7);
        first_reg = 4'd10;
        last_reg  = 4'd11;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        @(negedge CLK);
        chk("abort_w2_valid", 32'(s_if.out_valid), 32'd1);
        chk("abort_w2_addr",  32'(s_if.out_addr),  32'd5);
        tick();
        abort = 1'b0;
        @(negedge CLK);
        chk("abort_valid", 32'(s_if.out_valid), 32'd0);
        chk("abort_hold",  32'(hold_cpu),       32'd0);
        chk("abort_busy",  32'(busy),           32'd0);
        chk("abort_done",  32'(done),           32'd0);
        chk("abort_cnt",   32'(rx_cnt - base),  32'd1);
        @(negedge CLK);
        chk("abort_idle",  32'(busy),           32'd0);
        tick();

        // Start and abort together in IDLE
        first_reg = 4'd0;
        last_reg  = 4'd0;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge CLK);
        chk("start_abort_idle", 32'(busy), 32'd0);
        tick();

        // Reset while stalled in SEND
        ready_mode = 2;
        start_dump(4'd2, 4'd5);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (s_if.out_valid) seen = 1'b1;
        end
        chk("rst_mid_reach_send", 32'(seen), 32'd1);
        tick();
        RESET = 1'b0;
        tick();
        @(negedge CLK);
        chk("rstm_valid",  32'(s_if.out_valid), 32'd0);
        chk("rstm_data",   32'(s_if.out_data),  32'd0);
        chk("rstm_addr",   32'(s_if.out_addr),  32'd0);
        chk("rstm_last",   32'(s_if.out_last),  32'd0);
        chk("rstm_rdaddr", 32'(rd_addr),        32'd0);
        chk("rstm_busy",   32'(busy),           32'd0);
        chk("rstm_hold",   32'(hold_cpu),       32'd0);
        chk("rstm_done",   32'(done),           32'd0);
        tick();
        RESET      = 1'b1;
        ready_mode = 0;
        @(negedge CLK);
        chk("rstm_no_done", 32'(done), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug read-out engine for the 16 x 16-bit CPU register file. On a start pulse it takes ownership of one register-file read port and walks an inclusive, possibly wrapping, register range. Each register value is emitted on a valid/ready stream toward the debug/display path. While the dump runs, the block holds the CPU so that no writes occur and the snapshot stays consistent.

## Interface
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  reset, synchronous and active-low
- start  input  1  one-cycle request to begin a dump; honoured only when busy=0
- abort  input  1  cancel an in-progress dump
- first_reg  input  ADDR_W  first register to dump, sampled with start
- last_reg  input  ADDR_W  last register to dump, sampled with start
- rd_addr  output  ADDR_W  address driven to register-file read port
- rd_data  input  DATA_W  combinational register-file read data for rd_addr
- hold_cpu  output  1  stall request to CPU; suppresses register-file writes
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts word
- out_data  output  DATA_W  register value
- out_addr  output  ADDR_W  register number of out_data
- out_last  output  1  marks final word of the dump
- busy  output  1  high from cycle after accepted start until return to IDLE
- done  output  1  one-cycle pulse when the last word has been accepted

## Operation
- States:
  - IDLE: busy=0, hold_cpu=0, out_valid=0
  - READ: rd_addr=cur, capture rd_data
  - SEND: out_valid=1, wait for handshake
  - DONE: done=1
- IDLE → READ on start: latch cur=first_reg, end=last_reg.
- READ → SEND unconditionally:
  - out_data←rd_data, out_addr←cur
  - out_last←(cur==end)
- SEND with out_valid & out_ready:
  - if cur==end → DONE
  - else cur←cur+1 mod 16 (15 wraps to 0) → READ
- DONE → IDLE unconditionally.
- Word count = ((last_reg − first_reg) mod 16) + 1. first==last gives 1 word. last_reg = first_reg−1 gives all 16 words.
- Stream rule: once out_valid=1, out_data/out_addr/out_last stay stable until accepted, except on abort or reset.
- hold_cpu=1 in READ, SEND and DONE.
- start while busy=1 is ignored; first_reg/last_reg are not resampled.
- abort (any non-IDLE state) → IDLE next edge:
  - out_valid, hold_cpu, busy → 0
  - no done pulse
  - abort outranks a same-cycle handshake; that word counts as not delivered.
- start and abort together in IDLE: abort wins, stay IDLE.
- rd_addr holds cur in all states; value outside READ is don't-care but must be a registered value, so no glitching.

## Timing
- Reset (RESET=0 at a rising edge) puts the block in IDLE with all outputs 0 on the next cycle, including out_data, out_addr, rd_addr, out_last and done. It overrides every other input, including mid-dump.
- Latency:
  - start at edge N → busy/hold_cpu high from cycle N+1 (READ)
  - first out_valid at N+2
- Per word: minimum 2 cycles (READ + SEND) with out_ready tied high. A 16-word dump with constant ready takes 32 cycles plus 1 DONE cycle.
- done is high for exactly the cycle after the final handshake. busy falls the cycle after that.
- hold_cpu asserts the same cycle as the first READ. The CPU must already be stalled, which the hold-in-READ contract guarantees, because rd_data is sampled combinationally in that cycle.
- Back-to-back dumps: start is accepted earliest in the cycle after DONE (IDLE).

## Structure
- Shared CPU package holds:
  - REG_ADDR_W=4, REG_DATA_W=16
  - state encoding localparams IDLE/READ/SEND/DONE (2-bit)
- Single module, no sub-module. One registered FSM plus the cur/end/output registers.
- Instantiated beside the register file. rd_addr/rd_data share the read-port mux with the decode stage, selected by hold_cpu.

## Test plan
- Reset mid-SEND (dump 2..5, hold out_ready=0, pull RESET low) → next cycle all outputs 0, state IDLE, no done.
- Dump first=3, last=5, registers preloaded r3=0x1111, r4=0x2222, r5=0x3333, out_ready=1 → three words (3,0x1111), (4,0x2222), (5,0x3333,last). done pulses at cycle N+7; busy low at N+8.
- Wrap: first=14, last=1 → addresses 14,15,0,1 in order, out_last only on 1. first=7, last=6 → all 16 words, 0x? values match preload.
- Backpressure: out_ready random 30% → every word is held stable while out_valid=1 and ready=0. No duplicates, no losses, hold_cpu high throughout.
- abort asserted in the same cycle as the handshake of word 2 of 4 → next cycle IDLE with out_valid=0, hold_cpu=0, no done. A start issued while busy earlier is ignored (first_reg change has no effect).
- first=last=9 → single word (9, r9) with out_last=1, then done.
